// File: rtl/axil_arb2.sv
// axil_arb2: two-source to one-sink AXI4-Lite arbiter.
// Grants one complete read or write transaction at a time, round-robin
// across sources, write before read within a source. The grant is
// registered; channel handshakes and payload are forwarded combinationally
// from the granted source. Interface bundles are flattened to s0_*, s1_*, m_*.
module axil_arb2 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // source 0
  input  logic                    s0_awvalid,
  output logic                    s0_awready,
  input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
  input  logic [2:0]              s0_awprot,
  input  logic                    s0_wvalid,
  output logic                    s0_wready,
  input  logic [DATA_WIDTH-1:0]   s0_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
  output logic                    s0_bvalid,
  input  logic                    s0_bready,
  output logic [1:0]              s0_bresp,
  input  logic                    s0_arvalid,
  output logic                    s0_arready,
  input  logic [ADDR_WIDTH-1:0]   s0_araddr,
  input  logic [2:0]              s0_arprot,
  output logic                    s0_rvalid,
  input  logic                    s0_rready,
  output logic [DATA_WIDTH-1:0]   s0_rdata,
  output logic [1:0]              s0_rresp,
  // source 1
  input  logic                    s1_awvalid,
  output logic                    s1_awready,
  input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
  input  logic [2:0]              s1_awprot,
  input  logic                    s1_wvalid,
  output logic                    s1_wready,
  input  logic [DATA_WIDTH-1:0]   s1_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
  output logic                    s1_bvalid,
  input  logic                    s1_bready,
  output logic [1:0]              s1_bresp,
  input  logic                    s1_arvalid,
  output logic                    s1_arready,
  input  logic [ADDR_WIDTH-1:0]   s1_araddr,
  input  logic [2:0]              s1_arprot,
  output logic                    s1_rvalid,
  input  logic                    s1_rready,
  output logic [DATA_WIDTH-1:0]   s1_rdata,
  output logic [1:0]              s1_rresp,
  // shared downstream slave
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [2:0]              m_awprot,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [1:0]              m_bresp,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [2:0]              m_arprot,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  // status
  output logic [1:0]              gnt,
  output logic                    busy
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_DATA} state_e;

  state_e     state_q, state_d;
  logic       sel_q, sel_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic [1:0] gnt_q, gnt_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;

  logic [1:0] wr_req, rd_req, req;
  logic       win;

  // granted-source view (valid only while gnt_q is non-zero)
  logic g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
  logic g_awready, g_wready, g_bvalid, g_arready, g_rvalid;

  assign wr_req = {s1_awvalid | s1_wvalid, s0_awvalid | s0_wvalid};
  assign rd_req = {s1_arvalid, s0_arvalid};
  assign req    = wr_req | rd_req;

  assign gnt  = gnt_q;
  assign busy = |gnt_q;

  // Select the control inputs of the currently granted source
  always_comb begin
    g_awvalid = sel_q ? s1_awvalid : s0_awvalid;
    g_wvalid  = sel_q ? s1_wvalid  : s0_wvalid;
    g_bready  = sel_q ? s1_bready  : s0_bready;
    g_arvalid = sel_q ? s1_arvalid : s0_arvalid;
    g_rready  = sel_q ? s1_rready  : s0_rready;
  end

  // State, grant and write-channel completion registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      rr_ptr_q  <= 1'b0;
      gnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Arbitration, next state and channel handshake forwarding
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    win       = 1'b0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    g_awready = 1'b0;
    g_wready  = 1'b0;
    g_bvalid  = 1'b0;
    g_arready = 1'b0;
    g_rvalid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          win     = (&req) ? rr_ptr_q : req[1];
          sel_d   = win;
          gnt_d   = win ? 2'b10 : 2'b01;
          state_d = wr_req[win] ? WR : RD;
        end
      end
      WR: begin
        // aw and w complete independently in either order; a finished
        // channel is gated off until both are done
        m_awvalid = g_awvalid & ~aw_done_q;
        g_awready = m_awready & ~aw_done_q;
        m_wvalid  = g_wvalid & ~w_done_q;
        g_wready  = m_wready & ~w_done_q;
        aw_done_d = aw_done_q | (m_awvalid & m_awready);
        w_done_d  = w_done_q | (m_wvalid & m_wready);
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: begin
        m_bready = g_bready;
        g_bvalid = m_bvalid;
        if (m_bvalid && g_bready) begin
          state_d  = IDLE;
          rr_ptr_d = ~sel_q;
          gnt_d    = '0;
        end
      end
      RD: begin
        m_arvalid = g_arvalid;
        g_arready = m_arready;
        if (g_arvalid && m_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        m_rready = g_rready;
        g_rvalid = m_rvalid;
        if (m_rvalid && g_rready) begin
          state_d  = IDLE;
          rr_ptr_d = ~sel_q;
          gnt_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Route handshakes and payload to/from the granted source; others see zeros
  always_comb begin
    s0_awready = gnt_q[0] & g_awready;
    s0_wready  = gnt_q[0] & g_wready;
    s0_bvalid  = gnt_q[0] & g_bvalid;
    s0_arready = gnt_q[0] & g_arready;
    s0_rvalid  = gnt_q[0] & g_rvalid;
    s0_bresp   = gnt_q[0] ? m_bresp : '0;
    s0_rresp   = gnt_q[0] ? m_rresp : '0;
    s0_rdata   = gnt_q[0] ? m_rdata : '0;
    s1_awready = gnt_q[1] & g_awready;
    s1_wready  = gnt_q[1] & g_wready;
    s1_bvalid  = gnt_q[1] & g_bvalid;
    s1_arready = gnt_q[1] & g_arready;
    s1_rvalid  = gnt_q[1] & g_rvalid;
    s1_bresp   = gnt_q[1] ? m_bresp : '0;
    s1_rresp   = gnt_q[1] ? m_rresp : '0;
    s1_rdata   = gnt_q[1] ? m_rdata : '0;
    m_awaddr   = gnt_q[1] ? s1_awaddr : (gnt_q[0] ? s0_awaddr : '0);
    m_awprot   = gnt_q[1] ? s1_awprot : (gnt_q[0] ? s0_awprot : '0);
    m_wdata    = gnt_q[1] ? s1_wdata  : (gnt_q[0] ? s0_wdata  : '0);
    m_wstrb    = gnt_q[1] ? s1_wstrb  : (gnt_q[0] ? s0_wstrb  : '0);
    m_araddr   = gnt_q[1] ? s1_araddr : (gnt_q[0] ? s0_araddr : '0);
    m_arprot   = gnt_q[1] ? s1_arprot : (gnt_q[0] ? s0_arprot : '0);
  end

endmodule

// File: tb/tb_axil_arb2.sv
// tb_axil_arb2: randomized bench for axil_arb2 with a transaction-level
// reference model (round-robin owner, per-transaction phase, register
// memory) and a behavioural AXI-Lite slave.
module tb_axil_arb2;
  localparam int DW = 32;
  localparam int AW = 32;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic          s_awvalid [2], s_awready [2], s_wvalid [2], s_wready [2];
  logic          s_bvalid [2], s_bready [2], s_arvalid [2], s_arready [2];
  logic          s_rvalid [2], s_rready [2];
  logic [AW-1:0] s_awaddr [2], s_araddr [2];
  logic [2:0]    s_awprot [2], s_arprot [2];
  logic [DW-1:0] s_wdata [2], s_rdata [2];
  logic [3:0]    s_wstrb [2];
  logic [1:0]    s_bresp [2], s_rresp [2];

  logic          m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic          m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [2:0]    m_awprot, m_arprot;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [3:0]    m_wstrb;
  logic [1:0]    m_bresp, m_rresp;
  logic [1:0]    gnt;
  logic          busy;

  axil_arb2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_awvalid(s_awvalid[0]), .s0_awready(s_awready[0]), .s0_awaddr(s_awaddr[0]), .s0_awprot(s_awprot[0]),
    .s0_wvalid(s_wvalid[0]), .s0_wready(s_wready[0]), .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]),
    .s0_bvalid(s_bvalid[0]), .s0_bready(s_bready[0]), .s0_bresp(s_bresp[0]),
    .s0_arvalid(s_arvalid[0]), .s0_arready(s_arready[0]), .s0_araddr(s_araddr[0]), .s0_arprot(s_arprot[0]),
    .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]), .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]),
    .s1_awvalid(s_awvalid[1]), .s1_awready(s_awready[1]), .s1_awaddr(s_awaddr[1]), .s1_awprot(s_awprot[1]),
    .s1_wvalid(s_wvalid[1]), .s1_wready(s_wready[1]), .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]),
    .s1_bvalid(s_bvalid[1]), .s1_bready(s_bready[1]), .s1_bresp(s_bresp[1]),
    .s1_arvalid(s_arvalid[1]), .s1_arready(s_arready[1]), .s1_araddr(s_araddr[1]), .s1_arprot(s_arprot[1]),
    .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]), .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .gnt(gnt), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // source-side operation state
  bit          wr_act [2], aw_sent [2], w_sent [2], rd_act [2], ar_sent [2];
  logic [31:0] wr_addr [2], wr_data [2], rd_addr [2];
  logic [3:0]  wr_strb [2];
  int          aw_dly [2], w_dly [2], b_blk [2], r_blk [2];
  bit          gen_en = 1'b0;
  int          rdy_pct = 100;

  // behavioural slave
  logic [31:0] smem [64];
  bit          sl_aw_got, sl_w_got, sl_b_pend, sl_r_pend;
  logic [31:0] sl_awaddr, sl_wdata, sl_araddr;
  logic [3:0]  sl_wstrb;
  logic [1:0]  sl_bresp;
  int          sl_aw_blk;

  // reference model
  logic [31:0] rmem [64];
  bit          md_busy, md_wr, md_rr;
  int          md_own, md_aw, md_w, md_ar;
  logic [31:0] md_addr, md_data;
  logic [3:0]  md_strb;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    case (a[7:6])
      2'b10:   return 2'b10;
      2'b11:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    return {24'h0, 6'($urandom_range(0, 63)), 2'b00};
  endfunction

  function automatic bit quiet();
    return !md_busy && !wr_act[0] && !wr_act[1] && !rd_act[0] && !rd_act[1];
  endfunction

  task automatic inject_wr(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                           input int ad, input int wd);
    wr_act[i] = 1'b1; aw_sent[i] = 1'b0; w_sent[i] = 1'b0;
    wr_addr[i] = a; wr_data[i] = d; wr_strb[i] = st; aw_dly[i] = ad; w_dly[i] = wd;
  endtask

  task automatic inject_rd(input int i, input logic [31:0] a);
    rd_act[i] = 1'b1; ar_sent[i] = 1'b0; rd_addr[i] = a;
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (gen_en) begin
        if (!wr_act[i] && $urandom_range(99) < 12)
          inject_wr(i, rand_addr(), $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
        if (!rd_act[i] && $urandom_range(99) < 10) inject_rd(i, rand_addr());
      end
      if (aw_dly[i] > 0) aw_dly[i]--;
      if (w_dly[i] > 0) w_dly[i]--;
      s_awvalid[i] = wr_act[i] && !aw_sent[i] && aw_dly[i] == 0;
      s_wvalid[i]  = wr_act[i] && !w_sent[i] && w_dly[i] == 0;
      s_arvalid[i] = rd_act[i] && !ar_sent[i];
      s_awaddr[i]  = wr_addr[i];
      s_wdata[i]   = wr_data[i];
      s_wstrb[i]   = wr_strb[i];
      s_araddr[i]  = rd_addr[i];
      s_awprot[i]  = (i == 0) ? 3'b001 : 3'b010;
      s_arprot[i]  = (i == 0) ? 3'b101 : 3'b110;
      s_bready[i]  = (b_blk[i] == 0) && ($urandom_range(99) < rdy_pct);
      s_rready[i]  = (r_blk[i] == 0) && ($urandom_range(99) < rdy_pct);
    end
    m_awready = !sl_aw_got && sl_aw_blk == 0 && ($urandom_range(99) < rdy_pct);
    if (sl_aw_blk > 0) sl_aw_blk--;
    m_wready  = !sl_w_got && ($urandom_range(99) < rdy_pct);
    m_bvalid  = sl_b_pend;
    m_bresp   = sl_b_pend ? sl_bresp : 2'($urandom);
    m_arready = !sl_r_pend && ($urandom_range(99) < rdy_pct);
    m_rvalid  = sl_r_pend;
    m_rdata   = sl_r_pend ? smem[sl_araddr[7:2]] : $urandom;
    m_rresp   = sl_r_pend ? resp_of(sl_araddr) : 2'($urandom);
  endtask

  task automatic sample();
    int o;
    bit wrph, bph, arph, rph, own;
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [4:0] em, es;
    bit rq [2], wrq [2];
    int w;
    o = md_own;
    wrph = md_busy && md_wr && !(md_aw > 0 && md_w > 0);
    bph  = md_busy && md_wr && md_aw > 0 && md_w > 0;
    arph = md_busy && !md_wr && md_ar == 0;
    rph  = md_busy && !md_wr && md_ar > 0;
    chk("gnt", gnt, md_busy ? ((o == 1) ? 2'b10 : 2'b01) : 2'b00);
    chk("busy", busy, md_busy);
    em = {wrph & s_awvalid[o] & (md_aw == 0), wrph & s_wvalid[o] & (md_w == 0),
          bph & s_bready[o], arph & s_arvalid[o], rph & s_rready[o]};
    es = {wrph & m_awready & (md_aw == 0), wrph & m_wready & (md_w == 0),
          bph & m_bvalid, arph & m_arready, rph & m_rvalid};
    chk("m_ctl", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, em);
    for (int i = 0; i < 2; i++) begin
      own = md_busy && (o == i);
      chk((i == 0) ? "s0_ctl" : "s1_ctl", {s_awready[i], s_wready[i], s_bvalid[i], s_arready[i], s_rvalid[i]},
          own ? es : 5'b0);
      chk((i == 0) ? "s0_pay" : "s1_pay", {s_bresp[i], s_rresp[i], s_rdata[i]},
          own ? {m_bresp, m_rresp, m_rdata} : 36'h0);
    end
    chk("m_wpay", {m_awaddr, m_awprot, m_wdata, m_wstrb},
        md_busy ? {s_awaddr[o], s_awprot[o], s_wdata[o], s_wstrb[o]} : 71'h0);
    chk("m_rpay", {m_araddr, m_arprot}, md_busy ? {s_araddr[o], s_arprot[o]} : 35'h0);

    aw_hs = m_awvalid & m_awready;
    w_hs  = m_wvalid & m_wready;
    b_hs  = m_bvalid & m_bready;
    ar_hs = m_arvalid & m_arready;
    r_hs  = m_rvalid & m_rready;

    // reference model
    if (md_busy) begin
      if (aw_hs) md_aw++;
      if (w_hs) md_w++;
      if (ar_hs) md_ar++;
      if (md_wr && s_bvalid[o] && s_bready[o]) begin
        chk("aw_count", md_aw, 1);
        chk("w_count", md_w, 1);
        chk("bresp", s_bresp[o], resp_of(md_addr));
        rmem[md_addr[7:2]] = merge(rmem[md_addr[7:2]], md_data, md_strb);
        md_busy = 1'b0;
        md_rr = (o == 0);
      end else if (!md_wr && s_rvalid[o] && s_rready[o]) begin
        chk("ar_count", md_ar, 1);
        chk("rdata", s_rdata[o], rmem[md_addr[7:2]]);
        chk("rresp", s_rresp[o], resp_of(md_addr));
        md_busy = 1'b0;
        md_rr = (o == 0);
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        wrq[i] = s_awvalid[i] | s_wvalid[i];
        rq[i]  = wrq[i] | s_arvalid[i];
      end
      if (rq[0] || rq[1]) begin
        w = (rq[0] && rq[1]) ? int'(md_rr) : (rq[1] ? 1 : 0);
        md_busy = 1'b1;
        md_own = w;
        md_wr = wrq[w];
        md_addr = md_wr ? wr_addr[w] : rd_addr[w];
        md_data = wr_data[w];
        md_strb = wr_strb[w];
        md_aw = 0; md_w = 0; md_ar = 0;
      end
    end

    // source bookkeeping
    for (int i = 0; i < 2; i++) begin
      if (s_awvalid[i] && s_awready[i]) aw_sent[i] = 1'b1;
      if (s_wvalid[i] && s_wready[i]) w_sent[i] = 1'b1;
      if (s_bvalid[i] && s_bready[i]) wr_act[i] = 1'b0;
      if (s_arvalid[i] && s_arready[i]) ar_sent[i] = 1'b1;
      if (s_rvalid[i] && s_rready[i]) rd_act[i] = 1'b0;
      if (s_bvalid[i] && b_blk[i] > 0) b_blk[i]--;
      if (s_rvalid[i] && r_blk[i] > 0) r_blk[i]--;
    end

    // slave bookkeeping
    if (b_hs) sl_b_pend = 1'b0;
    if (r_hs) sl_r_pend = 1'b0;
    if (aw_hs) begin sl_aw_got = 1'b1; sl_awaddr = m_awaddr; end
    if (w_hs) begin sl_w_got = 1'b1; sl_wdata = m_wdata; sl_wstrb = m_wstrb; end
    if (sl_aw_got && sl_w_got) begin
      smem[sl_awaddr[7:2]] = merge(smem[sl_awaddr[7:2]], sl_wdata, sl_wstrb);
      sl_bresp = resp_of(sl_awaddr);
      sl_b_pend = 1'b1;
      sl_aw_got = 1'b0;
      sl_w_got = 1'b0;
    end
    if (ar_hs) begin sl_r_pend = 1'b1; sl_araddr = m_araddr; end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1 drive();
    @(negedge aclk);
    sample();
  endtask

  task automatic run_until_quiet(input int max);
    int k;
    k = 0;
    while (!quiet() && k < max) begin
      cyc();
      k++;
    end
    chk("quiet", quiet(), 1'b1);
    cyc();
    cyc();
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_gnt"}, {gnt, busy}, 3'b0);
    chk({tag, "_m"}, {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 5'b0);
    chk({tag, "_mpay"}, {m_awaddr, m_awprot, m_wdata, m_wstrb, m_araddr, m_arprot}, 106'h0);
    for (int i = 0; i < 2; i++)
      chk({tag, "_s"}, {s_awready[i], s_wready[i], s_bvalid[i], s_arready[i], s_rvalid[i],
                        s_bresp[i], s_rresp[i], s_rdata[i]}, 41'h0);
  endtask

  task automatic clear_all();
    for (int i = 0; i < 2; i++) begin
      wr_act[i] = 0; aw_sent[i] = 0; w_sent[i] = 0; rd_act[i] = 0; ar_sent[i] = 0;
      aw_dly[i] = 0; w_dly[i] = 0; b_blk[i] = 0; r_blk[i] = 0;
      wr_addr[i] = '0; wr_data[i] = '0; wr_strb[i] = '0; rd_addr[i] = '0;
    end
    sl_aw_got = 0; sl_w_got = 0; sl_b_pend = 0; sl_r_pend = 0; sl_aw_blk = 0;
    sl_awaddr = '0; sl_wdata = '0; sl_wstrb = '0; sl_araddr = '0; sl_bresp = '0;
    md_busy = 0; md_wr = 0; md_rr = 0; md_own = 0; md_aw = 0; md_w = 0; md_ar = 0;
    md_addr = '0; md_data = '0; md_strb = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    for (int a = 0; a < 64; a++) begin
      smem[a] = 32'hA5000000 | 32'(a);
      rmem[a] = smem[a];
    end
    clear_all();

    // both sources request writes out of reset; reset-state outputs checked
    inject_wr(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    inject_wr(1, 32'h14, 32'hCAFEF00D, 4'hF, 0, 0);
    drive();
    #12 chk_idle_outs("rst");
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    sample();
    run_until_quiet(50);
    inject_wr(0, 32'h18, 32'h01020304, 4'hF, 0, 0);
    inject_wr(1, 32'h1C, 32'h05060708, 4'hF, 0, 0);
    run_until_quiet(50);

    // single s0 write
    inject_wr(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    run_until_quiet(50);

    // s0 write + s0 read together, s1 read pending
    smem[16] = 32'h12345678;
    rmem[16] = 32'h12345678;
    inject_wr(1, 32'h20, 32'h11112222, 4'h3, 0, 0);
    run_until_quiet(50);
    inject_wr(0, 32'h24, 32'h33334444, 4'hF, 0, 0);
    inject_rd(0, 32'h40);
    inject_rd(1, 32'h40);
    run_until_quiet(80);

    // wvalid leads awvalid; slave stalls awready
    inject_wr(0, 32'h28, 32'h55667788, 4'hC, 4, 0);
    sl_aw_blk = 6;
    run_until_quiet(60);

    // SLVERR read with s1 holding rready low while rvalid is up
    inject_rd(1, 32'h80);
    r_blk[1] = 4;
    run_until_quiet(60);

    // randomized traffic
    gen_en = 1'b1;
    rdy_pct = 60;
    for (int c = 0; c < 1500; c++) cyc();
    gen_en = 1'b0;
    run_until_quiet(300);

    // reset during WR_RESP
    rdy_pct = 100;
    inject_wr(0, 32'h30, 32'h9ABCDEF0, 4'hF, 0, 0);
    b_blk[0] = 100;
    k = 0;
    while (!(md_busy && md_wr && md_aw > 0 && md_w > 0) && k < 40) begin
      cyc();
      k++;
    end
    chk("rst_reach", md_busy && md_wr && md_aw > 0 && md_w > 0, 1'b1);
    cyc();
    chk("rst_bvalid", s_bvalid[0], 1'b1);
    #2 aresetn = 1'b0;
    #1 chk_idle_outs("rst_mid");
    clear_all();
    for (int a = 0; a < 64; a++) rmem[a] = smem[a];
    @(posedge aclk);
    #1 drive();
    @(posedge aclk);
    #1 aresetn = 1'b1;
    inject_rd(1, 32'h44);
    @(negedge aclk);
    sample();
    run_until_quiet(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
